fork_dispatch_sched: RTL

Packet scheduler in front of the multi-channel fork send path. Takes one 64-bit AXI-Stream of PAICORE frames from DMA and steers each packet (tlast-delimited) whole to one of Channel output lanes, either round-robin or by a route field in the first frame. One output register per lane, per-lane packet-done pulses and a drop path for packets aimed at disabled lanes.

---
 rtl/fork_dispatch_sched.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fork_dispatch_sched.sv
// fork_dispatch_sched: steers whole tlast-delimited packets from one AXI-Stream input onto one of
// Channel output lanes, round-robin or by a route field in the first beat. Packets aimed at a
// disabled lane are consumed and dropped.
// Optional build macro: FORK_DISPATCH_STAT_EN adds a saturating forwarded-beat counter on
// o_frame_cnt; without it o_frame_cnt is tied to zero.
module fork_dispatch_sched #(
    parameter int unsigned Channel    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ROUTE_LSB  = 60,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_aresetn,
    input  logic                          cfg_route_mode,
    input  logic [Channel-1:0]            cfg_chan_en,
    output logic                          s_axis_tready,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    input  logic [Channel-1:0]            m_axis_tready,
    output logic [Channel*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [Channel-1:0]            m_axis_tlast,
    output logic [Channel-1:0]            m_axis_tvalid,
    output logic                          o_busy,
    output logic [Channel-1:0]            o_pkt_done,
    output logic                          o_err_drop,
    output logic [CNT_WIDTH-1:0]          o_frame_cnt
);

    localparam int unsigned CW = $clog2(Channel);
    localparam int unsigned NumSel = 1 << CW;

    typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

    state_e state_q, state_d;

    logic [CW-1:0] sel_q;
    logic [CW-1:0] rr_last_q;

    // Enable mask padded to the full select range so out-of-range route values read as disabled.
    logic [NumSel-1:0] en_pad;

    logic [CW-1:0] rr_sel;
    logic          rr_found;
    logic [CW:0]   rr_idx;
    logic [CW-1:0] route_sel;
    logic          route_ok;
    logic [CW-1:0] pick_sel;
    logic          pick_ok;

    logic                  fwd_hs;
    logic                  pkt_start;
    logic [DATA_WIDTH-1:0] lane_data_q [Channel];
    logic [Channel-1:0]    lane_valid_q;
    logic [Channel-1:0]    lane_last_q;
    logic [Channel-1:0]    pkt_done_q;
    logic                  err_drop_q;

    // Lane selection: round-robin search and route-field decode, evaluated while idle.
    always_comb begin
        en_pad = '0;
        en_pad[Channel-1:0] = cfg_chan_en;

        rr_sel   = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        // Search upward from the lane after rr_last, wrapping; the last probe revisits rr_last.
        for (int unsigned k = 1; k <= Channel; k++) begin
            rr_idx = {1'b0, rr_last_q} + (CW+1)'(k);
            if (rr_idx >= (CW+1)'(Channel)) begin
                rr_idx = rr_idx - (CW+1)'(Channel);
            end
            if (!rr_found && en_pad[rr_idx[CW-1:0]]) begin
                rr_found = 1'b1;
                rr_sel   = rr_idx[CW-1:0];
            end
        end

        route_sel = s_axis_tdata[ROUTE_LSB +: CW];
        route_ok  = en_pad[route_sel];

        pick_sel = cfg_route_mode ? route_sel : rr_sel;
        pick_ok  = cfg_route_mode ? route_ok : rr_found;
    end

    assign pkt_start = (state_q == StIdle) && s_axis_tvalid;
    assign fwd_hs    = (state_q == StFwd) && s_axis_tvalid && s_axis_tready;

    // FSM state register.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: packet start picks FWD or DROP, a tlast handshake returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (s_axis_tvalid) begin
                    state_d = pick_ok ? StFwd : StDrop;
                end
            end
            StFwd, StDrop: begin
                if (s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: input ready is withheld while idle and follows the selected lane in FWD.
    always_comb begin
        s_axis_tready = 1'b0;
        unique case (state_q)
            StFwd:   s_axis_tready = !lane_valid_q[sel_q] || m_axis_tready[sel_q];
            StDrop:  s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
        endcase
    end

    // Latch the chosen lane per packet; round-robin pointer advances only on a forwarded start.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            sel_q     <= '0;
            rr_last_q <= CW'(Channel - 1);
        end else if (pkt_start) begin
            sel_q <= pick_sel;
            if (!cfg_route_mode && pick_ok) begin
                rr_last_q <= pick_sel;
            end
        end
    end

    // Drop pulse is registered so it lands on the first DROP cycle.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            err_drop_q <= 1'b0;
        end else begin
            err_drop_q <= pkt_start && !pick_ok;
        end
    end

    // Per-lane output registers: load from the input on a FWD handshake, drain independently.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            for (int i = 0; i < Channel; i++) begin
                lane_data_q[i] <= '0;
            end
            lane_valid_q <= '0;
            lane_last_q  <= '0;
        end else begin
            for (int i = 0; i < Channel; i++) begin
                if (fwd_hs && (sel_q == CW'(i))) begin
                    lane_data_q[i]  <= s_axis_tdata;
                    lane_last_q[i]  <= s_axis_tlast;
                    lane_valid_q[i] <= 1'b1;
                end else if (m_axis_tready[i]) begin
                    lane_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Packet-done pulses follow a tlast handshake on each lane by one cycle.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            pkt_done_q <= '0;
        end else begin
            pkt_done_q <= lane_valid_q & m_axis_tready & lane_last_q;
        end
    end

    // Flatten lane registers onto the output bus.
    always_comb begin
        m_axis_tdata = '0;
        for (int i = 0; i < Channel; i++) begin
            m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = lane_data_q[i];
        end
    end

    assign m_axis_tvalid = lane_valid_q;
    assign m_axis_tlast  = lane_last_q;
    assign o_pkt_done    = pkt_done_q;
    assign o_err_drop    = err_drop_q;
    assign o_busy        = (state_q != StIdle) || (|lane_valid_q);

`ifdef FORK_DISPATCH_STAT_EN
    logic [CNT_WIDTH-1:0] frame_cnt_q;

    // Saturating count of forwarded input beats; only reset clears it.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            frame_cnt_q <= '0;
        end else if (fwd_hs && !(&frame_cnt_q)) begin
            frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`else
    assign o_frame_cnt = '0;
`endif

endmodule
